// File: rtl/wb_arbiter_pkg.sv
// Shared wishbone definitions: data/select widths and the arbiter FSM encoding.
// wb_arbiter and wb_decoder both import this package.
package wb_arbiter_pkg;

  localparam int DW   = 32;
  localparam int SELW = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of per-master request/response signals plus the single downstream bus.
// Handshake: a master holds mst_stb_i until it sees its mst_ack_o bit; a transfer ends on
// the cycle where ack_i & stb_o are both high (mst_err_o marks a forced timeout ending).
interface wb_arbiter_if #(
  parameter int MASTERS = 4,
  parameter int AW      = 32
);
  import wb_arbiter_pkg::*;

  logic [MASTERS-1:0]      mst_stb_i;
  logic [MASTERS-1:0]      mst_we_i;
  logic [MASTERS*AW-1:0]   mst_adr_i;
  logic [MASTERS*DW-1:0]   mst_dat_i;
  logic [MASTERS*SELW-1:0] mst_sel_i;
  logic [MASTERS-1:0]      mst_ack_o;
  logic [MASTERS-1:0]      mst_err_o;
  logic [DW-1:0]           mst_dat_o;

  logic                    stb_o;
  logic                    we_o;
  logic [AW-1:0]           adr_o;
  logic [DW-1:0]           dat_o;
  logic [SELW-1:0]         sel_o;
  logic                    ack_i;
  logic [DW-1:0]           dat_i;

  // Arbiter side: it is the slave of the masters and drives the downstream bus.
  modport slave (
    input  mst_stb_i, mst_we_i, mst_adr_i, mst_dat_i, mst_sel_i, ack_i, dat_i,
    output mst_ack_o, mst_err_o, mst_dat_o, stb_o, we_o, adr_o, dat_o, sel_o
  );

  // Environment side: masters plus the downstream slave response.
  modport master (
    output mst_stb_i, mst_we_i, mst_adr_i, mst_dat_i, mst_sel_i, ack_i, dat_i,
    input  mst_ack_o, mst_err_o, mst_dat_o, stb_o, we_o, adr_o, dat_o, sel_o
  );

endinterface

// File: rtl/wb_rr_pick.sv
// Round-robin priority select: first set request at or above ptr_i, wrapping to 0.
module wb_rr_pick #(
  parameter int N  = 4,
  parameter int MW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [MW-1:0] ptr_i,
  output logic [MW-1:0] idx_o,
  output logic          valid_o
);

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!valid_o && req_i[(int'(ptr_i) + k) % N]) begin
        valid_o = 1'b1;
        idx_o   = MW'((int'(ptr_i) + k) % N);
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin wishbone arbiter: one transfer per grant, one IDLE cycle between grants,
// and a timeout that forces an error termination when the slave never acks.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter  int MASTERS = 4,
  parameter  int AW      = 32,
  parameter  int TIMEOUT = 255,
  localparam int MW      = $clog2(MASTERS)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  wb_arbiter_if.slave      bus,
  output arb_state_t       dbg_state_o,
  output logic [MW-1:0]    dbg_gnt_o,
  output logic [MW-1:0]    dbg_ptr_o
);

  localparam int CW = $clog2(TIMEOUT);

  arb_state_t        r_state;
  logic [MW-1:0]     r_gnt;
  logic [MW-1:0]     r_ptr;
  logic [CW-1:0]     r_cnt;

  logic              w_busy;
  logic              w_req_g;
  logic              w_timeout;
  logic              w_acked;
  logic              w_done;
  logic              w_pick_valid;
  logic [MW-1:0]     w_pick;
  logic [MASTERS-1:0] w_gnt_oh;

  wb_rr_pick #(.N(MASTERS), .MW(MW)) u_pick (
    .req_i   (bus.mst_stb_i),
    .ptr_i   (r_ptr),
    .idx_o   (w_pick),
    .valid_o (w_pick_valid)
  );

  assign w_busy   = (r_state == ST_BUSY);
  assign w_req_g  = bus.mst_stb_i[r_gnt];
  // An ack on the last allowed cycle wins over the timeout.
  assign w_timeout = w_busy && w_req_g && !bus.ack_i && (r_cnt == CW'(TIMEOUT - 1));
  assign w_acked  = bus.ack_i && bus.stb_o;
  assign w_done   = w_acked || w_timeout || !w_req_g;
  assign w_gnt_oh = MASTERS'(1) << r_gnt;

  assign bus.stb_o     = w_busy && w_req_g && !w_timeout;
  assign bus.we_o      = w_busy && bus.mst_we_i[r_gnt];
  assign bus.adr_o     = w_busy ? bus.mst_adr_i[int'(r_gnt)*AW +: AW]     : '0;
  assign bus.dat_o     = w_busy ? bus.mst_dat_i[int'(r_gnt)*DW +: DW]     : '0;
  assign bus.sel_o     = w_busy ? bus.mst_sel_i[int'(r_gnt)*SELW +: SELW] : '0;
  assign bus.mst_ack_o = (w_acked || w_timeout) ? w_gnt_oh : '0;
  assign bus.mst_err_o = w_timeout ? w_gnt_oh : '0;
  assign bus.mst_dat_o = bus.dat_i;

  assign dbg_state_o = r_state;
  assign dbg_gnt_o   = r_gnt;
  assign dbg_ptr_o   = r_ptr;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_gnt   <= w_pick;
            r_cnt   <= '0;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_done) begin
            r_ptr   <= (r_gnt == MW'(MASTERS - 1)) ? '0 : r_gnt + 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a vector table for single transfers plus hand-written
// sequences for timeout, ack-at-timeout, abort, back-to-back rotation and mid-transfer reset.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int M  = 4;
  localparam int AW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_arbiter_if #(.MASTERS(M), .AW(AW)) bus();
  arb_state_t dbg_state;
  logic [1:0] dbg_gnt;
  logic [1:0] dbg_ptr;

  wb_arbiter #(.MASTERS(M), .AW(AW), .TIMEOUT(TO)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state),
    .dbg_gnt_o   (dbg_gnt),
    .dbg_ptr_o   (dbg_ptr)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] m_adr [M];
  logic [31:0] m_dat [M];
  logic        m_we  [M];
  logic [3:0]  m_sel [M];

  typedef struct {
    logic [3:0]  req;
    int          wait_cyc;
    logic [31:0] rdata;
    logic [1:0]  exp_gnt;
    logic [1:0]  exp_ptr;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_busy(input int g, input string tag);
    chk({tag, "_stb_o"}, 64'(bus.stb_o), 64'(1));
    chk({tag, "_adr_o"}, 64'(bus.adr_o), 64'(m_adr[g]));
    chk({tag, "_dat_o"}, 64'(bus.dat_o), 64'(m_dat[g]));
    chk({tag, "_we_o"},  64'(bus.we_o),  64'(m_we[g]));
    chk({tag, "_sel_o"}, 64'(bus.sel_o), 64'(m_sel[g]));
    chk({tag, "_gnt"},   64'(dbg_gnt),   64'(g));
  endtask

  initial begin
    m_adr[0] = 32'h0000_0A00; m_dat[0] = 32'h1111_1111; m_we[0] = 1'b0; m_sel[0] = 4'h1;
    m_adr[1] = 32'h0000_0B04; m_dat[1] = 32'h2222_2222; m_we[1] = 1'b0; m_sel[1] = 4'h3;
    m_adr[2] = 32'h0000_0100; m_dat[2] = 32'hCAFE_F00D; m_we[2] = 1'b1; m_sel[2] = 4'hF;
    m_adr[3] = 32'hFFFF_FFFC; m_dat[3] = 32'h4444_4444; m_we[3] = 1'b1; m_sel[3] = 4'hC;
    for (int i = 0; i < M; i++) begin
      bus.mst_adr_i[i*AW +: AW] = m_adr[i];
      bus.mst_dat_i[i*32 +: 32] = m_dat[i];
      bus.mst_we_i[i]           = m_we[i];
      bus.mst_sel_i[i*4 +: 4]   = m_sel[i];
    end

    // ptr evolves 0 -> 3 -> 0 -> 1 -> 3 -> 1 -> 0 -> 2 across the table.
    vecs[0] = '{4'b0100, 1, 32'hA5A5_0001, 2'd2, 2'd3};
    vecs[1] = '{4'b1111, 0, 32'hA5A5_0002, 2'd3, 2'd0};
    vecs[2] = '{4'b0011, 2, 32'hA5A5_0003, 2'd0, 2'd1};
    vecs[3] = '{4'b0101, 0, 32'hA5A5_0004, 2'd2, 2'd3};
    vecs[4] = '{4'b0001, 3, 32'hA5A5_0005, 2'd0, 2'd1};
    vecs[5] = '{4'b1000, 0, 32'hA5A5_0006, 2'd3, 2'd0};
    vecs[6] = '{4'b0010, 6, 32'hA5A5_0007, 2'd1, 2'd2};

    // Reset with every master requesting and the slave acking: nothing may leak out.
    bus.mst_stb_i = 4'b1111;
    bus.ack_i     = 1'b1;
    bus.dat_i     = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("rst_stb_o", 64'(bus.stb_o), 64'(0));
    chk("rst_ack",   64'(bus.mst_ack_o), 64'(0));
    chk("rst_err",   64'(bus.mst_err_o), 64'(0));
    chk("rst_ptr",   64'(dbg_ptr), 64'(0));
    chk("rst_gnt",   64'(dbg_gnt), 64'(0));
    chk("rst_adr_o", 64'(bus.adr_o), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    bus.mst_stb_i = '0;
    bus.ack_i = 1'b0;

    for (int v = 0; v < 7; v++) begin
      @(negedge clk);
      bus.mst_stb_i = vecs[v].req;
      bus.ack_i = 1'b0;
      #1;
      chk("vec_idle_stb_o", 64'(bus.stb_o), 64'(0));
      for (int c = 0; c <= vecs[v].wait_cyc; c++) begin
        @(negedge clk);
        if (c == vecs[v].wait_cyc) begin
          bus.ack_i = 1'b1;
          bus.dat_i = vecs[v].rdata;
        end
        #1;
        check_busy(int'(vecs[v].exp_gnt), "vec");
        chk("vec_ack", 64'(bus.mst_ack_o),
            (c == vecs[v].wait_cyc) ? (64'(1) << vecs[v].exp_gnt) : 64'(0));
        chk("vec_err", 64'(bus.mst_err_o), 64'(0));
      end
      chk("vec_rdata", 64'(bus.mst_dat_o), 64'(vecs[v].rdata));
      @(negedge clk);
      bus.ack_i = 1'b0;
      bus.mst_stb_i = '0;
      #1;
      chk("vec_state", 64'(dbg_state), 64'(ST_IDLE));
      chk("vec_ptr", 64'(dbg_ptr), 64'(vecs[v].exp_ptr));
      chk("vec_ack_after", 64'(bus.mst_ack_o), 64'(0));
    end

    // Master 1 read, slave silent: forced error termination on the 8th BUSY cycle.
    @(negedge clk);
    bus.mst_stb_i = 4'b0010;
    for (int c = 0; c < TO; c++) begin
      @(negedge clk);
      #1;
      chk("to_gnt", 64'(dbg_gnt), 64'(1));
      chk("to_we_o", 64'(bus.we_o), 64'(0));
      chk("to_stb_o", 64'(bus.stb_o), (c < TO-1) ? 64'(1) : 64'(0));
      chk("to_ack", 64'(bus.mst_ack_o), (c < TO-1) ? 64'(0) : 64'(4'b0010));
      chk("to_err", 64'(bus.mst_err_o), (c < TO-1) ? 64'(0) : 64'(4'b0010));
    end
    @(negedge clk);
    bus.mst_stb_i = '0;
    #1;
    chk("to_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("to_ptr", 64'(dbg_ptr), 64'(2));

    // Ack lands exactly on the timeout cycle: normal termination.
    @(negedge clk);
    bus.mst_stb_i = 4'b0010;
    for (int c = 0; c < TO; c++) begin
      @(negedge clk);
      if (c == TO-1) begin
        bus.ack_i = 1'b1;
        bus.dat_i = 32'h1234_5678;
      end
      #1;
    end
    chk("toack_stb_o", 64'(bus.stb_o), 64'(1));
    chk("toack_ack", 64'(bus.mst_ack_o), 64'(4'b0010));
    chk("toack_err", 64'(bus.mst_err_o), 64'(0));
    chk("toack_dat", 64'(bus.mst_dat_o), 64'(32'h1234_5678));
    @(negedge clk);
    bus.ack_i = 1'b0;
    bus.mst_stb_i = '0;
    #1;
    chk("toack_state", 64'(dbg_state), 64'(ST_IDLE));

    // Master 3 abandons its request mid-transfer; a stray ack must not reach it.
    @(negedge clk);
    bus.mst_stb_i = 4'b1000;
    @(negedge clk);
    #1;
    check_busy(3, "abort");
    @(negedge clk);
    bus.mst_stb_i = '0;
    bus.ack_i = 1'b1;
    #1;
    chk("abort_stb_o", 64'(bus.stb_o), 64'(0));
    chk("abort_ack", 64'(bus.mst_ack_o), 64'(0));
    @(negedge clk);
    #1;
    chk("abort_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("abort_ptr", 64'(dbg_ptr), 64'(0));
    chk("abort_idle_ack", 64'(bus.mst_ack_o), 64'(0));
    bus.ack_i = 1'b0;

    // All masters request continuously, slave acks at once: 0,1,2,3,0 with IDLE gaps.
    @(negedge clk);
    bus.mst_stb_i = 4'b1111;
    bus.ack_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("b2b_stb_o", 64'(bus.stb_o), (i % 2 == 0) ? 64'(1) : 64'(0));
      chk("b2b_ack", 64'(bus.mst_ack_o),
          (i % 2 == 0) ? (64'(1) << ((i / 2) % 4)) : 64'(0));
      if (i % 2 == 0) chk("b2b_adr_o", 64'(bus.adr_o), 64'(m_adr[(i / 2) % 4]));
    end
    bus.mst_stb_i = '0;
    bus.ack_i = 1'b0;
    @(negedge clk);
    #1;
    chk("b2b_ptr", 64'(dbg_ptr), 64'(1));

    // Reset while master 2 is granted; afterwards the search restarts at master 0.
    @(negedge clk);
    bus.mst_stb_i = 4'b0100;
    @(negedge clk);
    #1;
    chk("mrst_pre_gnt", 64'(dbg_gnt), 64'(2));
    chk("mrst_pre_stb_o", 64'(bus.stb_o), 64'(1));
    rst_n = 1'b0;
    bus.ack_i = 1'b1;
    #1;
    chk("mrst_stb_o", 64'(bus.stb_o), 64'(0));
    chk("mrst_ack", 64'(bus.mst_ack_o), 64'(0));
    chk("mrst_err", 64'(bus.mst_err_o), 64'(0));
    chk("mrst_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("mrst_ptr", 64'(dbg_ptr), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    bus.ack_i = 1'b0;
    bus.mst_stb_i = 4'b0101;
    @(negedge clk);
    #1;
    check_busy(0, "mrst_post");
    bus.mst_stb_i = '0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
